// File: rtl/hs32_prefetch_if.sv
// hs32_prefetch_if: bundles the prefetch stage's memory-arbiter, decoder
// and redirect signals. The master modport is the prefetch stage itself;
// the slave modport is its environment (arbiter, decoder, pipeline control).
// Optional macro HS32_PREFETCH_PCTAG_EN adds the pcd fetch-address output.
interface hs32_prefetch_if #(
    parameter int unsigned XLEN = 32
);
    // Memory arbiter side
    logic [XLEN-1:0] addr;
    logic            reqm;
    logic [XLEN-1:0] dtr;
    logic            ackm;
    // Decoder side
    logic [XLEN-1:0] instd;
    logic            ackd;
    logic            reqd;
    // Redirect from the pipeline controller
    logic [XLEN-1:0] newpc;
    logic            flush;
`ifdef HS32_PREFETCH_PCTAG_EN
    logic [XLEN-1:0] pcd;

    modport master (
        output addr, reqm, instd, ackd, pcd,
        input  dtr, ackm, reqd, newpc, flush
    );

    modport slave (
        input  addr, reqm, instd, ackd, pcd,
        output dtr, ackm, reqd, newpc, flush
    );
`else
    modport master (
        output addr, reqm, instd, ackd,
        input  dtr, ackm, reqd, newpc, flush
    );

    modport slave (
        input  addr, reqm, instd, ackd,
        output dtr, ackm, reqd, newpc, flush
    );
`endif
endinterface

// File: rtl/hs32_prefetch.sv
// hs32_prefetch: sequential instruction prefetcher for the hs32 core.
// Issues one outstanding read at a time to the memory arbiter, buffers the
// returned words in a DEPTH-entry FIFO for the decoder, and throttles new
// requests so that buffered words plus the outstanding read never exceed
// DEPTH. A flush redirects the PC; a read already in flight when the flush
// arrives is completed and its data discarded (DRAIN state).
// DEPTH must be a power of two >= 2 with PBITS = log2(DEPTH).
// Optional macro HS32_PREFETCH_PCTAG_EN: adds pcd, the fetch address of
// the word currently on instd, held in a parallel tag FIFO.
module hs32_prefetch #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     PBITS    = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    hs32_prefetch_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // no request outstanding
        ST_REQ   = 2'd1,   // request outstanding, data will be kept
        ST_DRAIN = 2'd2    // request outstanding, data will be discarded
    } state_t;

    localparam logic [PBITS:0]  DEPTH_P = (PBITS+1)'(DEPTH);
    localparam logic [PBITS:0]  ONE_P   = (PBITS+1)'(1);
    localparam logic [XLEN-1:0] STEP_P  = XLEN'(PC_STEP);

    state_t          r_state;
    logic [XLEN-1:0] r_pc;      // address of the next word to keep
    logic [XLEN-1:0] r_addr;    // address presented to the arbiter
    logic [PBITS:0]  r_wp;
    logic [PBITS:0]  r_rp;
    logic [XLEN-1:0] r_fifo [DEPTH];
`ifdef HS32_PREFETCH_PCTAG_EN
    logic [XLEN-1:0] r_tag  [DEPTH];
`endif

    state_t          w_state_n;
    logic [XLEN-1:0] w_pc_n;
    logic [XLEN-1:0] w_addr_n;
    logic [PBITS:0]  w_wp_n;
    logic [PBITS:0]  w_rp_n;
    logic [XLEN-1:0] w_pc_inc;
    logic [PBITS:0]  w_fill;
    logic [PBITS:0]  w_fill_next;
    logic            w_ackd;
    logic            w_push;
    logic            w_pop;
    logic            w_credit;

    // Occupancy and handshake qualifiers. Pointers carry one extra wrap bit
    // so a full FIFO (fill == DEPTH) is distinguishable from an empty one.
    always_comb begin
        w_fill      = r_wp - r_rp;
        w_ackd      = (w_fill != '0);
        w_push      = (r_state == ST_REQ) && bus.ackm && !bus.flush;
        w_pop       = w_ackd && bus.reqd && !bus.flush;
        w_fill_next = w_fill + (PBITS+1)'(w_push) - (PBITS+1)'(w_pop);
        // After this edge the FIFO holds w_fill_next words; one more request
        // may be in flight only if that still leaves room for its data.
        w_credit    = (w_fill_next < DEPTH_P);
        w_pc_inc    = r_pc + STEP_P;
    end

    // Next-state, pointer and fetch-address logic.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_state_n = r_state;
        w_pc_n    = r_pc;
        w_addr_n  = r_addr;
        w_wp_n    = w_push ? (r_wp + ONE_P) : r_wp;
        w_rp_n    = w_pop  ? (r_rp + ONE_P) : r_rp;

        if (bus.flush) begin
            // Redirect: buffered words are stale, so empty the FIFO.
            w_wp_n = '0;
            w_rp_n = '0;
            w_pc_n = bus.newpc;
            case (r_state)
                ST_IDLE: begin
                    w_state_n = ST_REQ;
                    w_addr_n  = bus.newpc;
                end
                ST_REQ, ST_DRAIN: begin
                    if (bus.ackm) begin
                        // The in-flight word returns on this very edge and
                        // is dropped, so the redirect can issue right away.
                        w_state_n = ST_REQ;
                        w_addr_n  = bus.newpc;
                    end else begin
                        // Keep addr stable until the stale read completes.
                        w_state_n = ST_DRAIN;
                    end
                end
                default: w_state_n = ST_IDLE;
            endcase
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_credit) begin
                        w_state_n = ST_REQ;
                        w_addr_n  = r_pc;
                    end
                end
                ST_REQ: begin
                    if (bus.ackm) begin
                        w_pc_n = w_pc_inc;
                        if (w_credit) begin
                            w_addr_n = w_pc_inc;
                        end else begin
                            w_state_n = ST_IDLE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (bus.ackm) begin
                        w_state_n = ST_REQ;
                        w_addr_n  = r_pc;
                    end
                end
                default: w_state_n = ST_IDLE;
            endcase
        end
    end

    // State register, PC, fetch address and FIFO pointers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
            r_addr  <= RESET_PC;
            r_wp    <= '0;
            r_rp    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            r_state <= w_state_n;
            r_pc    <= w_pc_n;
            r_addr  <= w_addr_n;
            r_wp    <= w_wp_n;
            r_rp    <= w_rp_n;
        end
    end

    // Instruction storage, written with the returned word on each push.
    // NOTE: the data array is deliberately not reset; an entry is only read
    // out while ackd=1, i.e. after it has been written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wp[PBITS-1:0]] <= bus.dtr;
        end
    end

`ifdef HS32_PREFETCH_PCTAG_EN
    // Fetch-address tags, written alongside the data with the same pointers.
    // Cleared on reset so pcd shows RESET_PC until the first word arrives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_tag[i] <= RESET_PC;
            end
        end else if (w_push) begin
            r_tag[r_wp[PBITS-1:0]] <= r_addr;
        end
    end

    assign bus.pcd = r_tag[r_rp[PBITS-1:0]];
`endif

    assign bus.addr  = r_addr;
    assign bus.reqm  = (r_state != ST_IDLE);
    assign bus.instd = r_fifo[r_rp[PBITS-1:0]];
    assign bus.ackd  = w_ackd;

endmodule

// File: tb/tb_hs32_prefetch.sv
// tb_hs32_prefetch: self-checking bench for hs32_prefetch.
// Inputs are driven on the falling edge; outputs are compared there too,
// against a scoreboard of expected {address, word} entries pushed when an
// accepted memory transfer is driven and popped when the decoder takes one.
module tb_hs32_prefetch;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    hs32_prefetch_if #(.XLEN(XLEN)) bus ();

    hs32_prefetch #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .PBITS    (2),
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } entry_t;

    entry_t      sb[$];
    logic [31:0] exp_addr;
    bit          drain;
    bit          exp_reqm;
    int          n_checks = 0;
    int          n_errors = 0;

    // Arbiter memory contents: an injective scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        exp_addr = 32'h0;
        drain    = 1'b0;
        exp_reqm = 1'b0;
    endtask

    // One clock cycle, entered and left on a falling edge.
    task automatic step(input bit ack, input bit rd, input bit fl, input logic [31:0] npc);
        bit     m_ackd;
        entry_t e;
        m_ackd = (sb.size() != 0);
        check("reqm", 32'(bus.reqm), 32'(exp_reqm));
        check("ackd", 32'(bus.ackd), 32'(m_ackd));
        if (m_ackd) begin
            check("instd", bus.instd, sb[0].d);
`ifdef HS32_PREFETCH_PCTAG_EN
            check("pcd", bus.pcd, sb[0].a);
`endif
        end
        if (exp_reqm && !drain) begin
            check("addr", bus.addr, exp_addr);
        end

        bus.ackm  = ack;
        bus.dtr   = bus.reqm ? mem_word(bus.addr) : 32'($urandom);
        bus.reqd  = rd;
        bus.flush = fl;
        bus.newpc = fl ? npc : 32'($urandom);

        if (fl) begin
            sb.delete();
            exp_addr = npc;
            drain    = exp_reqm && !ack;
        end else begin
            if (m_ackd && rd) begin
                void'(sb.pop_front());
            end
            if (exp_reqm && ack) begin
                if (drain) begin
                    drain = 1'b0;
                end else begin
                    e.a = exp_addr;
                    e.d = mem_word(exp_addr);
                    sb.push_back(e);
                    exp_addr = exp_addr + 32'd4;
                end
            end
        end
        exp_reqm = drain || (sb.size() < DEPTH);
        @(negedge clk);
    endtask

    // Assert reset between clock edges and check the immediate effect.
    task automatic pulse_reset();
        bus.ackm  = 1'b1;
        bus.flush = 1'b0;
        bus.reqd  = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("rst_reqm", 32'(bus.reqm), 32'h0);
        check("rst_ackd", 32'(bus.ackd), 32'h0);
        check("rst_addr", bus.addr, 32'h0);
`ifdef HS32_PREFETCH_PCTAG_EN
        check("rst_pcd", bus.pcd, 32'h0);
`endif
        model_reset();
        // ackm held high during reset must have no effect.
        repeat (2) @(negedge clk);
        check("rst_hold_reqm", 32'(bus.reqm), 32'h0);
        reset_n = 1'b1;
    endtask

    initial begin
        bus.ackm  = 1'b0;
        bus.dtr   = '0;
        bus.reqd  = 1'b0;
        bus.flush = 1'b0;
        bus.newpc = '0;
        model_reset();

        // Reset state, then fill from RESET_PC with acks every cycle.
        @(negedge clk);
        check("init_reqm", 32'(bus.reqm), 32'h0);
        check("init_ackd", 32'(bus.ackd), 32'h0);
        check("init_addr", bus.addr, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) step(1'b1, 1'b0, 1'b0, 32'h0);

        // Steady stream: ack and accept every cycle.
        repeat (20) step(1'b1, 1'b1, 1'b0, 32'h0);

        // Flush while the read to 0x8 is outstanding; it returns 3 cycles later.
        pulse_reset();
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0100);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        repeat (6) step(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (4) step(1'b0, 1'b1, 1'b0, 32'h0);

        // Repeated flush while draining: the latest target wins.
        step(1'b0, 1'b1, 1'b1, 32'h0000_0300);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0340);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        repeat (5) step(1'b1, 1'b1, 1'b0, 32'h0);

        // Flush coincident with ackm (and with a pop): no drain cycle.
        step(1'b1, 1'b1, 1'b1, 32'h0000_0200);
        repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);

        // Flush right at the top of the address space; pc wraps to zero.
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
        repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);

        // Random arbiter/decoder timing with rare flushes: exercises full
        // FIFO, simultaneous push/pop and pointer wrap.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 29) == 0,
                 32'($urandom) & 32'hFFFF_FFFC);
        end

        // Reset while a request is outstanding, then restart from RESET_PC.
        repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);
        check("pre_rst_reqm", 32'(bus.reqm), 32'h1);
        pulse_reset();
        repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hs32_prefetch.md
Name: hs32_prefetch

Overview:
Parametrised successor to the CPU fetch stage: issues sequential instruction reads to the memory arbiter and buffers returned words in a DEPTH-entry FIFO for the decoder. Adds proper reset, request/acknowledge handshakes on both sides, credit-based request throttling, and flush/redirect with in-flight discard. Sits between the memory arbiter and hs32 decode; the pipeline controller drives redirects.

Parameters:
XLEN, 32, instruction/address width in bits
DEPTH, 4, FIFO entries; power of two, >= 2
PBITS, 2, log2(DEPTH); pointers are PBITS+1 bits wide
RESET_PC, 0, PC loaded on reset
PC_STEP, 4, byte increment per fetched instruction

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
addr  out  XLEN  fetch address to arbiter
reqm  out  1  fetch request valid
dtr  in  XLEN  read data from arbiter
ackm  in  1  read data valid; completes the request
instd  out  XLEN  FIFO head instruction
ackd  out  1  instd valid (FIFO non-empty)
reqd  in  1  decoder accepts instd this cycle
newpc  in  XLEN  redirect target
flush  in  1  one-cycle redirect strobe

Behaviour:
- Reset (reset_n low, async): reqm=0, addr=RESET_PC, ackd=0, instd=don't-care, pc=RESET_PC, wp=rp=0, state=IDLE. First reqm rises on the first clk edge after reset_n deasserts.
- Memory handshake: at most one outstanding request. addr and reqm are registered and held stable until the edge where ackm=1 is sampled; that edge is the transfer. ackm with reqm=0 is ignored.
- Credit: new request issued only if fill + outstanding < DEPTH (fill = wp - rp, PBITS+1 bits, wraps modulo 2^(PBITS+1)). The FIFO never overflows; no data is dropped except on flush.
- On transfer: dtr written at fifo[wp[PBITS-1:0]], wp+1, pc+PC_STEP (wraps modulo 2^XLEN). If credit allows, reqm stays high and addr updates to the new pc on the same edge (back-to-back, one word per cycle sustained).
- Latency: data accepted at edge N is visible on instd with ackd=1 after edge N (one cycle).
- Decode handshake: ackd = (fill != 0). Pop occurs at an edge with ackd & reqd; rp+1. Push and pop on the same edge are both honoured; fill is unchanged.
- FSM:
  - IDLE: reqm=0. Goes to REQ when credit is available.
  - REQ: reqm=1. On ackm: push, then go to REQ if credit remains, else IDLE.
  - DRAIN: reqm=1, addr held at the stale address. On ackm: discard dtr, then go to REQ at the redirected pc.
- Flush (sampled at an edge): wp=rp=0, ackd=0 next cycle, pc=newpc.
  - From IDLE, or from REQ with ackm=0 on that edge: REQ→DRAIN if a request is outstanding, else go to REQ with addr=newpc.
  - Flush and ackm on the same edge: returned data is discarded, no DRAIN, next request goes to newpc.
  - Flush and reqd on the same edge: flush wins; the pop is irrelevant.
  - A flush during DRAIN updates pc to the latest newpc and stays in DRAIN.
- newpc is ignored when flush=0.
- reset_n asserted mid-transfer: all state is cleared immediately; any later ackm is ignored because reqm=0.

Optional Feature:
HS32_PREFETCH_PCTAG_EN:
- Defined: adds output port pcd (XLEN) carrying the fetch address of instd. A parallel DEPTH-entry tag FIFO is written with addr on each push and follows the same pointers. pcd resets to RESET_PC.
- Undefined: no pcd port and no tag storage; behaviour is otherwise identical.

Test Plan:
- Reset release, arbiter acks every cycle, reqd=0 → addr 0,4,8,12; reqm falls after 4 acks; ackd=1, instd=word@0; fill=4 with no overflow.
- Steady stream, ackm=1 and reqd=1 every cycle → one instruction per cycle in address order; reqm never drops after the first ack.
- Flush with newpc=0x100 while a request to 0x8 is outstanding (ackm 3 cycles later) → DRAIN; word@0x8 discarded; next addr=0x100; ackd=0 until the 0x100 data arrives.
- Flush coincident with ackm → that data is discarded, next addr=newpc, no DRAIN cycle.
- Full FIFO plus simultaneous push/pop edge → fill stays constant; pointers wrap past 2^(PBITS+1) with order preserved; no lost or duplicated words.
- reset_n pulsed low while reqm=1 → reqm=0 and ackd=0 immediately; after release, first addr=RESET_PC. With HS32_PREFETCH_PCTAG_EN defined, pcd matches each instd's address throughout.
